// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
// Optional signed mode is selected in the top with SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

   localparam int DEFAULT_DIV_DATA_LEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } t_div_state;

   // Width of an iteration counter that can hold the value data_len.
   function automatic int div_cnt_width(input int data_len);
      return $clog2(data_len + 1);
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// div_restoring_step: one combinational radix-2 restoring division step,
// shared by every iteration of seq_divider.
module div_restoring_step
   import seq_divider_pkg::*;
#(
   parameter int DATA_LEN = DEFAULT_DIV_DATA_LEN
) (
   input  logic [DATA_LEN:0]   rem_in,
   input  logic                dividend_msb,
   input  logic [DATA_LEN-1:0] divisor,
   output logic [DATA_LEN:0]   rem_out,
   output logic                q_bit
);

   logic [DATA_LEN+1:0] shifted;
   logic [DATA_LEN:0]   diff;

   // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
   always_comb begin
      shifted = {rem_in, dividend_msb};
      q_bit   = (shifted >= {2'b00, divisor});
      // When the trial succeeds the true difference is below the divisor, so
      // the truncated subtraction is exact.
      diff    = shifted[DATA_LEN:0] - {1'b0, divisor};
      rem_out = q_bit ? diff : shifted[DATA_LEN:0];
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider with ready/valid handshakes.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (default: unsigned).
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int DATA_LEN = DEFAULT_DIV_DATA_LEN
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] quotient,
   output logic [DATA_LEN-1:0] remainder,
   output logic                div_by_zero
);

   localparam int CNT_W = div_cnt_width(DATA_LEN);

   t_div_state          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_LEN:0]   rem_q, rem_d;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [DATA_LEN-1:0] dvd_q, dvd_d;
   logic [DATA_LEN-1:0] dvs_q, dvs_d;
   logic [DATA_LEN-1:0] quo_q, quo_d;
   logic [DATA_LEN-1:0] rmd_q, rmd_d;
   logic                dbz_q, dbz_d;

   logic [DATA_LEN:0]   step_rem;
   logic                step_bit;
   logic [DATA_LEN-1:0] op_a, op_b;
   logic [DATA_LEN-1:0] res_quo, res_rmd;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic                sign_quo_q, sign_quo_d;
   logic                sign_rem_q, sign_rem_d;
`endif

   div_restoring_step #(
      .DATA_LEN (DATA_LEN)
   ) u_step (
      .rem_in       (rem_q),
      .dividend_msb (dvd_q[DATA_LEN-1]),
      .divisor      (dvs_q),
      .rem_out      (step_rem),
      .q_bit        (step_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      op_a    = a;
      op_b    = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sign_quo_d = sign_quo_q;
      sign_rem_d = sign_rem_q;
      if (a[DATA_LEN-1]) op_a = -a;
      if (b[DATA_LEN-1]) op_b = -b;
`endif

      // Result of the final step; a zero divisor skips iteration and the
      // still-unshifted dividend register holds the original magnitude.
      res_quo = {dvd_q[DATA_LEN-2:0], step_bit};
      res_rmd = step_rem[DATA_LEN-1:0];
      if (dvs_q == '0) begin
         res_quo = '1;
         res_rmd = dvd_q;
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (sign_quo_q && (dvs_q != '0)) res_quo = -res_quo;
      if (sign_rem_q)                  res_rmd = -res_rmd;
`endif

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvd_d   = op_a;
               dvs_d   = op_b;
               rem_d   = '0;
               cnt_d   = (b == '0) ? CNT_W'(1) : CNT_W'(DATA_LEN);
               state_d = BUSY;
`ifdef SEQ_DIVIDER_SIGNED_EN
               sign_quo_d = a[DATA_LEN-1] ^ b[DATA_LEN-1];
               sign_rem_d = a[DATA_LEN-1];
`endif
            end
         end
         BUSY: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[DATA_LEN-2:0], step_bit};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               quo_d   = res_quo;
               rmd_d   = res_rmd;
               dbz_d   = (dvs_q == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; datapath
   // registers are reset too so the result outputs read zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         sign_quo_q <= 1'b0;
         sign_rem_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
         sign_quo_q <= sign_quo_d;
         sign_rem_q <= sign_rem_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider against an arithmetic
// reference model; follows SEQ_DIVIDER_SIGNED_EN when it is defined.
`timescale 1ns/1ps
module tb_seq_divider;

   localparam int DW    = 32;
   localparam int LIMIT = 200;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [DW-1:0] remainder;
   logic          div_by_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seq_divider #(
      .DATA_LEN (DW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   // Reference model: quotient/remainder from plain arithmetic.
   function automatic void ref_div(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                   output logic [DW-1:0] q, output logic [DW-1:0] r,
                                   output logic z);
      z = (y == '0);
      if (z) begin
         q = '1;
         r = x;
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      else if (x == {1'b1, {(DW-1){1'b0}}} && y == '1) begin
         q = x;
         r = '0;
      end else begin
         q = DW'($signed(x) / $signed(y));
         r = DW'($signed(x) % $signed(y));
      end
`else
      else begin
         q = x / y;
         r = x % y;
      end
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait for in_ready, pass the accept edge.
   task automatic issue(input logic [DW-1:0] a_i, input logic [DW-1:0] b_i,
                        output int acc_cyc, output bit to);
      int n = 0;
      in_valid = 1'b1;
      a = a_i;
      b = b_i;
      while (!in_ready && n < LIMIT) begin
         step();
         n++;
      end
      to = !in_ready;
      step();
      acc_cyc  = cyc;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   // Step until out_valid; lat = edges after accept, ready_hi = in_ready seen while busy.
   task automatic wait_result(output int lat, output int ready_hi, output bit to);
      lat = 0;
      ready_hi = 0;
      while (!out_valid && lat < LIMIT) begin
         if (in_ready) ready_hi++;
         step();
         lat++;
      end
      to = !out_valid;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      repeat (3) step();
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 ||
          remainder !== '0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got in_ready=%b out_valid=%b q=%h r=%h dbz=%b, expected 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_ops();
      vec_t vecs[$];
      logic [DW-1:0] eq, er;
      logic ez;
      int acc, lat, rh, exp_lat;
      bit to1, to2;
      vecs.push_back('{a: 32'd100,        b: 32'd7});
      vecs.push_back('{a: 32'd5,          b: 32'd0});
      vecs.push_back('{a: 32'd0,          b: 32'd1});
      vecs.push_back('{a: 32'd6,          b: 32'd6});
      vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF});
      vecs.push_back('{a: 32'hFFFF_FFF9,  b: 32'd2});
      vecs.push_back('{a: 32'h8000_0000,  b: 32'hFFFF_FFFF});
      vecs.push_back('{a: 32'h8000_0000,  b: 32'd0});
      for (int i = 0; i < 24; i++) begin
         vec_t v;
         v.a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
         v.b = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
         vecs.push_back(v);
      end
      foreach (vecs[i]) begin
         ref_div(vecs[i].a, vecs[i].b, eq, er, ez);
         exp_lat = ez ? 1 : DW;
         issue(vecs[i].a, vecs[i].b, acc, to1);
         wait_result(lat, rh, to2);
         checks++;
         if (to1 || to2 || lat != exp_lat || rh != 0) begin
            errors++;
            $display("FAIL op_timing[%0d] a=%h b=%h: got lat=%0d in_ready_busy=%0d timeout=%b%b, expected lat=%0d 0 00",
                     i, vecs[i].a, vecs[i].b, lat, rh, to1, to2, exp_lat);
         end
         checks++;
         if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL op_result[%0d] a=%h b=%h: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                     i, vecs[i].a, vecs[i].b, quotient, remainder, div_by_zero, eq, er, ez);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] q1, r1, eq1, er1, eq2, er2;
      logic z1, ez1, ez2;
      int acc1, acc2, lat, rh;
      bit t1, t2, t3, t4;
      ref_div(32'hFFFF_FFFF, 32'd1, eq1, er1, ez1);
      ref_div(32'd3, 32'hFFFF_FFFF, eq2, er2, ez2);
      out_ready = 1'b1;
      issue(32'hFFFF_FFFF, 32'd1, acc1, t1);
      wait_result(lat, rh, t2);
      q1 = quotient;
      r1 = remainder;
      z1 = div_by_zero;
      issue(32'd3, 32'hFFFF_FFFF, acc2, t3);
      wait_result(lat, rh, t4);
      checks++;
      if (q1 !== eq1 || r1 !== er1 || z1 !== ez1) begin
         errors++;
         $display("FAIL b2b_first: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b", q1, r1, z1, eq1, er1, ez1);
      end
      checks++;
      if (quotient !== eq2 || remainder !== er2 || div_by_zero !== ez2 || t4) begin
         errors++;
         $display("FAIL b2b_second: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                  quotient, remainder, div_by_zero, eq2, er2, ez2);
      end
      checks++;
      if (acc2 - acc1 != DW + 2 || t1 || t2 || t3) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d cycles between accepts, expected %0d", acc2 - acc1, DW + 2);
      end
      step();
   endtask

   task automatic test_stall();
      logic [DW-1:0] eq, er;
      logic ez;
      int acc, lat, rh, bad;
      bit t1, t2;
      ref_div(32'd1000, 32'd10, eq, er, ez);
      issue(32'd1000, 32'd10, acc, t1);
      wait_result(lat, rh, t2);
      out_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq ||
             remainder !== er || div_by_zero !== ez) bad++;
      end
      checks++;
      if (bad != 0 || t1 || t2) begin
         errors++;
         $display("FAIL stall_hold: got %0d unstable cycles (last q=%h r=%h), expected 0 with q=%h r=%h",
                  bad, quotient, remainder, eq, er);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [DW-1:0] eq, er;
      logic ez;
      int acc, lat, rh;
      bit t1, t2;
      issue(32'd12345, 32'd67, acc, t1);
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 ||
          remainder !== '0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_state: got out_valid=%b in_ready=%b q=%h r=%h dbz=%b, expected 0 1 0 0 0",
                  out_valid, in_ready, quotient, remainder, div_by_zero);
      end
      ref_div(32'd9, 32'd4, eq, er, ez);
      issue(32'd9, 32'd4, acc, t1);
      wait_result(lat, rh, t2);
      checks++;
      if (t1 || t2 || lat != DW || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
         errors++;
         $display("FAIL mid_reset_next: got lat=%0d q=%h r=%h dbz=%b, expected lat=%0d q=%h r=%h dbz=%b",
                  lat, quotient, remainder, div_by_zero, DW, eq, er, ez);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_stall();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
